// File: rtl/pkg_btn_evt.sv
// Shared types and limits for the button event arbiter.
package pkg_btn_evt;

    typedef enum logic {
        EVT_PRESS   = 1'b0,
        EVT_RELEASE = 1'b1
    } evt_type_t;

    typedef enum logic {
        ST_IDLE,
        ST_OFFER
    } arb_state_t;

    localparam int unsigned N_BTN_MAX = 16;

endpackage

// File: rtl/module_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module module_rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt_id,
    output logic          any_req
);

    // Scan from ptr upward with wrap; the first hit wins.
    always_comb begin
        int unsigned idx;
        logic [PW-1:0] sel;
        gnt_id  = '0;
        any_req = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            sel = PW'(idx);
            if (!any_req && req[sel]) begin
                any_req = 1'b1;
                gnt_id  = sel;
            end
        end
    end

endmodule

// File: rtl/module_btn_event_arbiter.sv
// Button edge detector and round-robin event arbiter with valid/ready output.
// Optional macro BTN_RELEASE_EVT_EN: also report falling edges as release events.
module module_btn_event_arbiter
    import pkg_btn_evt::*;
#(
    parameter  int N_BTN = 4,
    localparam int IDW   = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic [N_BTN-1:0] btn_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [IDW-1:0]   evt_id_o,
    output logic             evt_type_o,
    output logic [N_BTN-1:0] overrun_o,
    input  logic             clr_ovr_i
);

`ifdef BTN_RELEASE_EVT_EN
    localparam int unsigned NREQ = 2 * N_BTN;
`else
    localparam int unsigned NREQ = N_BTN;
`endif
    localparam int unsigned PW = $clog2(NREQ);

    arb_state_t       state_q, state_d;
    logic             load;
    logic             hs;
    logic [PW-1:0]    win_q;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    ptr_nxt;
    logic [PW-1:0]    gnt;
    logic             any_req;
    logic [NREQ-1:0]  req;

    logic             primed;
    logic [N_BTN-1:0] btn_q;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] pend_q, pend_d;
    logic [N_BTN-1:0] cons_p;
    logic [N_BTN-1:0] ovr_new, ovr_d;

    assign hs = (state_q == ST_OFFER) && evt_ready_i;

    // Edge detection is suppressed on the priming cycle so levels held through reset are not events.
    assign press  = primed ? (btn_i & ~btn_q) : '0;
    assign pend_d = press | (pend_q & ~cons_p);

`ifdef BTN_RELEASE_EVT_EN
    logic [N_BTN-1:0] rel;
    logic [N_BTN-1:0] rpend_q, rpend_d;
    logic [N_BTN-1:0] cons_r;

    assign rel     = primed ? (~btn_i & btn_q) : '0;
    assign rpend_d = rel | (rpend_q & ~cons_r);
    assign ovr_new = (press & pend_q & ~cons_p) | (rel & rpend_q & ~cons_r);

    // Request vector interleaves press/release per button: {.., rel1, press1, rel0, press0}.
    for (genvar g = 0; g < N_BTN; g++) begin : g_req
        assign req[2*g]     = pend_q[g];
        assign req[2*g+1]   = rpend_q[g];
        assign cons_p[g]    = hs && (win_q == PW'(2*g));
        assign cons_r[g]    = hs && (win_q == PW'(2*g+1));
    end

    // Release pending flags.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) rpend_q <= '0;
        else        rpend_q <= rpend_d;
    end

    assign evt_id_o   = win_q[PW-1:1];
    assign evt_type_o = win_q[0];
`else
    assign ovr_new = press & pend_q & ~cons_p;

    for (genvar g = 0; g < N_BTN; g++) begin : g_req
        assign req[g]    = pend_q[g];
        assign cons_p[g] = hs && (win_q == PW'(g));
    end

    assign evt_id_o   = win_q;
    assign evt_type_o = EVT_PRESS;
`endif

    // A fresh overrun in the clearing cycle survives the clear.
    assign ovr_d   = (clr_ovr_i ? '0 : overrun_o) | ovr_new;
    assign ptr_nxt = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);

    module_rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt_id  (gnt),
        .any_req (any_req)
    );

    // Button history, priming flag, press pending flags and sticky overrun.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            btn_q     <= '0;
            primed    <= 1'b0;
            pend_q    <= '0;
            overrun_o <= '0;
        end else begin
            btn_q     <= btn_i;
            primed    <= 1'b1;
            pend_q    <= pend_d;
            overrun_o <= ovr_d;
        end
    end

    // FSM state, latched winner (carries id/type) and round-robin pointer.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            rr_ptr  <= '0;
        end else begin
            state_q <= state_d;
            if (load) win_q  <= gnt;
            if (hs)   rr_ptr <= ptr_nxt;
        end
    end

    // Next-state: arbitrate only in IDLE, hold the offer until the handshake.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        evt_valid_o = (state_q == ST_OFFER);
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    load    = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (evt_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_module_btn_event_arbiter.sv
// Directed self-checking bench for module_btn_event_arbiter (N_BTN = 4).
module tb_module_btn_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [3:0] btn_i = '0;
    logic       evt_valid_o;
    logic       evt_ready_i = 1'b0;
    logic [1:0] evt_id_o;
    logic       evt_type_o;
    logic [3:0] overrun_o;
    logic       clr_ovr_i = 1'b0;

    int tests = 0;
    int fails = 0;

    module_btn_event_arbiter #(
        .N_BTN (4)
    ) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .btn_i       (btn_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_id_o    (evt_id_o),
        .evt_type_o  (evt_type_o),
        .overrun_o   (overrun_o),
        .clr_ovr_i   (clr_ovr_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with the given button level, release, and pass the priming edge.
    task automatic do_reset(input logic [3:0] lvl);
        rst_i = 1'b0;
        evt_ready_i = 1'b0;
        clr_ovr_i = 1'b0;
        btn_i = lvl;
        step();
        step();
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_reset();
        int bad;
        rst_i = 1'b0;
        #3;
        tests++; if (evt_valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", evt_valid_o); end
        tests++; if (evt_id_o !== 2'd0) begin fails++; $display("FAIL rst_id got %0d want 0", evt_id_o); end
        tests++; if (evt_type_o !== 1'b0) begin fails++; $display("FAIL rst_type got %b want 0", evt_type_o); end
        tests++; if (overrun_o !== 4'b0000) begin fails++; $display("FAIL rst_ovr got %b want 0000", overrun_o); end
        do_reset(4'b0001);
        evt_ready_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (evt_valid_o !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL held_through_reset got %0d valid cycles want 0", bad); end
    endtask

    task automatic test_single_press();
        int bad;
        do_reset(4'b0000);
        btn_i = 4'b0100;
        step();
        tests++; if (evt_valid_o !== 1'b0) begin fails++; $display("FAIL single_lat got %b want 0", evt_valid_o); end
        step();
        tests++; if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd2 || evt_type_o !== 1'b0) begin
            fails++; $display("FAIL single_offer got v%b id%0d t%b want v1 id2 t0", evt_valid_o, evt_id_o, evt_type_o);
        end
        evt_ready_i = 1'b1;
        step();
        tests++; if (evt_valid_o !== 1'b0) begin fails++; $display("FAIL single_hs got %b want 0", evt_valid_o); end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (evt_valid_o !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL single_cleared got %0d extra valid want 0", bad); end
        evt_ready_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic       exp_v [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0] exp_id[8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd3, 2'd0, 2'd0};
        do_reset(4'b0000);
        evt_ready_i = 1'b1;
        btn_i = 4'b1011;
        for (int i = 0; i < 8; i++) begin
            step();
            tests++;
            if (evt_valid_o !== exp_v[i] || (exp_v[i] && evt_id_o !== exp_id[i])) begin
                fails++;
                $display("FAIL simul_step%0d got v%b id%0d want v%b id%0d", i, evt_valid_o, evt_id_o, exp_v[i], exp_id[i]);
            end
        end
        evt_ready_i = 1'b0;
    endtask

    task automatic test_overrun();
        int bad;
        do_reset(4'b0000);
        btn_i = 4'b0010;
        step();
        step();
        tests++; if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd1) begin
            fails++; $display("FAIL ovr_offer got v%b id%0d want v1 id1", evt_valid_o, evt_id_o);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd1) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL ovr_hold got %0d unstable cycles want 0", bad); end
        btn_i = 4'b0000;
        step();
        btn_i = 4'b0010;
        step();
        tests++; if (overrun_o !== 4'b0010) begin fails++; $display("FAIL ovr_set got %b want 0010", overrun_o); end
        tests++; if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd1) begin
            fails++; $display("FAIL ovr_still got v%b id%0d want v1 id1", evt_valid_o, evt_id_o);
        end
        evt_ready_i = 1'b1;
        step();
        tests++; if (evt_valid_o !== 1'b0) begin fails++; $display("FAIL ovr_hs got %b want 0", evt_valid_o); end
        step();
`ifdef BTN_RELEASE_EVT_EN
        tests++; if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd1 || evt_type_o !== 1'b1) begin
            fails++; $display("FAIL ovr_rel got v%b id%0d t%b want v1 id1 t1", evt_valid_o, evt_id_o, evt_type_o);
        end
`else
        tests++; if (evt_valid_o !== 1'b0) begin fails++; $display("FAIL ovr_coalesce got %b want 0", evt_valid_o); end
`endif
        step();
        tests++; if (evt_valid_o !== 1'b0) begin fails++; $display("FAIL ovr_drained got %b want 0", evt_valid_o); end
        evt_ready_i = 1'b0;
        clr_ovr_i = 1'b1;
        step();
        clr_ovr_i = 1'b0;
        tests++; if (overrun_o !== 4'b0000) begin fails++; $display("FAIL ovr_clear got %b want 0000", overrun_o); end
        btn_i = 4'b0011;
        step();
        step();
        tests++; if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd0) begin
            fails++; $display("FAIL ovr2_offer got v%b id%0d want v1 id0", evt_valid_o, evt_id_o);
        end
        btn_i = 4'b0010;
        step();
        btn_i = 4'b0011;
        clr_ovr_i = 1'b1;
        step();
        clr_ovr_i = 1'b0;
        tests++; if (overrun_o !== 4'b0001) begin fails++; $display("FAIL ovr_set_beats_clr got %b want 0001", overrun_o); end
    endtask

    task automatic test_reset_mid_offer();
        int bad;
        do_reset(4'b0000);
        btn_i = 4'b1000;
        step();
        step();
        tests++; if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd3) begin
            fails++; $display("FAIL mid_offer got v%b id%0d want v1 id3", evt_valid_o, evt_id_o);
        end
        #2;
        rst_i = 1'b0;
        #1;
        tests++; if (evt_valid_o !== 1'b0) begin fails++; $display("FAIL mid_async got %b want 0", evt_valid_o); end
        tests++; if (evt_id_o !== 2'd0) begin fails++; $display("FAIL mid_id got %0d want 0", evt_id_o); end
        #2;
        rst_i = 1'b1;
        evt_ready_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (evt_valid_o !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL mid_no_event got %0d valid cycles want 0", bad); end
        evt_ready_i = 1'b0;
    endtask

    task automatic test_fairness();
        logic [1:0] gid[16];
        logic       gty[16];
        int n;
        int pos;
        int exp_pos;
        do_reset(4'b0000);
        evt_ready_i = 1'b1;
        n = 0;
        for (int s = 0; s < 16; s++) begin
            btn_i = {1'b1, 2'b00, ((s % 4) < 2) ? 1'b1 : 1'b0};
            step();
            if (evt_valid_o === 1'b1) begin
                gid[n] = evt_id_o;
                gty[n] = evt_type_o;
                n++;
            end
        end
        pos = -1;
        for (int i = n - 1; i >= 0; i--) begin
            if (gid[i] == 2'd3 && gty[i] == 1'b0) pos = i;
        end
`ifdef BTN_RELEASE_EVT_EN
        exp_pos = 2;
`else
        exp_pos = 1;
`endif
        tests++; if (n < 1 || gid[0] !== 2'd0) begin fails++; $display("FAIL fair_first got n%0d id%0d want id0", n, gid[0]); end
        tests++; if (pos != exp_pos) begin fails++; $display("FAIL fair_btn3 got grant %0d want %0d", pos, exp_pos); end
        evt_ready_i = 1'b0;
    endtask

    task automatic test_release();
        do_reset(4'b0000);
        btn_i = 4'b0001;
        step();
        step();
        tests++; if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd0 || evt_type_o !== 1'b0) begin
            fails++; $display("FAIL rel_press got v%b id%0d t%b want v1 id0 t0", evt_valid_o, evt_id_o, evt_type_o);
        end
        evt_ready_i = 1'b1;
        btn_i = 4'b0000;
        step();
        tests++; if (evt_valid_o !== 1'b0) begin fails++; $display("FAIL rel_hs got %b want 0", evt_valid_o); end
        step();
`ifdef BTN_RELEASE_EVT_EN
        tests++; if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd0 || evt_type_o !== 1'b1) begin
            fails++; $display("FAIL rel_event got v%b id%0d t%b want v1 id0 t1", evt_valid_o, evt_id_o, evt_type_o);
        end
`else
        tests++; if (evt_valid_o !== 1'b0) begin fails++; $display("FAIL rel_ignored got %b want 0", evt_valid_o); end
`endif
        step();
        tests++; if (evt_valid_o !== 1'b0) begin fails++; $display("FAIL rel_done got %b want 0", evt_valid_o); end
        evt_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_simultaneous();
        test_overrun();
        test_reset_mid_offer();
        test_fairness();
        test_release();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/module_btn_event_arbiter.md
Name: module_btn_event_arbiter

Overview:
Collects debounced button levels from N module_debouncer instances and detects edges. Holds one pending event per button and shares a single event output port between buttons. Buttons are served round-robin. It sits between the debouncer bank and the consumer (display/control FSM), which takes events over a valid/ready handshake.

Parameters:
N_BTN, 4, number of debounced button inputs (2..16)
IDW, $clog2(N_BTN), width of event id (derived, localparam)

Ports:
clk  input  1  system clock
rst_i  input  1  asynchronous active-low reset
btn_i  input  N_BTN  debounced button levels (signal_o of each debouncer), synchronous to clk
evt_valid_o  output  1  event offered to consumer
evt_ready_i  input  1  consumer accepts event
evt_id_o  output  IDW  index of button owning the offered event
evt_type_o  output  1  0 = press, 1 = release
overrun_o  output  N_BTN  sticky: edge lost because pending already set
clr_ovr_i  input  1  synchronous clear of overrun_o

Behaviour:
- Reset (rst_i=0, async): all registers are cleared.
  - btn_q=0, pending=0, overrun_o=0, evt_valid_o=0, evt_id_o=0, evt_type_o=0.
  - rr_ptr=0, primed=0, state=IDLE.
  - evt_valid_o drops immediately, even mid-offer.
- Priming: the first clk edge after reset release loads btn_q<=btn_i, sets primed, and generates no events. A button held through reset produces no press.
- Edge detect (primed=1):
  - press[i] = btn_i[i] & ~btn_q[i].
  - btn_q <= btn_i every cycle.
- Pending: press[i] sets pending[i].
  - If pending[i] is already 1 and is not being consumed this cycle: overrun_o[i] <= 1; pending stays 1 (events coalesce).
  - Consume and new edge on the same channel in the same cycle: pending stays 1, no overrun.
- FSM has two states.
  - IDLE: if any pending bit is set, the round-robin picks the first set bit at index >= rr_ptr, wrapping. The winner's id/type are registered, evt_valid_o<=1, and the FSM goes to OFFER. Otherwise it stays in IDLE.
  - OFFER: evt_valid_o=1. id and type are held stable until handshake.
    - On evt_valid_o & evt_ready_i: clear the winner's pending bit (subject to the rule above), rr_ptr <= (id+1) mod N_BTN, evt_valid_o<=0, go to IDLE.
    - With ready low: hold indefinitely. No re-arbitration; a higher-priority arrival waits.
- Latency: an edge detected at clk edge k gives pending at k and evt_valid_o=1 after edge k+1. Peak throughput is 1 event / 2 cycles.
- Overrun: clr_ovr_i clears all bits. A new overrun in the same cycle as clr_ovr_i wins (bit set).
- evt_ready_i while evt_valid_o=0 is ignored.

Optional Feature:
- Macro BTN_RELEASE_EVT_EN.
- Defined:
  - Falling edges (~btn_i & btn_q) set separate rel_pending[i], with the same overrun/coalesce rules (shared overrun_o bit).
  - The request vector is 2*N_BTN wide, ordered {press0, rel0, press1, rel1, ...}. rr_ptr indexes this vector.
  - Release events report evt_type_o=1.
- Undefined: falling edges are ignored, no rel_pending logic is built, and evt_type_o is tied 0.

Decomposition:
- Package pkg_btn_evt:
  - typedef enum logic {EVT_PRESS=1'b0, EVT_RELEASE=1'b1} evt_type_t;
  - typedef enum logic {ST_IDLE, ST_OFFER} arb_state_t;
  - localparam N_BTN_MAX=16.
- Sub-module module_rr_arbiter:
  - Parameter N.
  - Inputs req[N] and ptr; outputs gnt_id and any_req.
  - Purely combinational; first set bit at or after ptr, with wrap.
- Top holds the edge/pending registers and the FSM.

Test Plan:
- Single press: btn_i[2] 0->1 at edge 10 -> evt_valid_o=1 after edge 11, evt_id_o=2, evt_type_o=0. Ready high gives one handshake, then valid=0 and pending[2]=0.
- Simultaneous presses: btn_i 0000->1011, ready always 1, rr_ptr=0 -> ids 0,1,3 in order, 2 cycles apart, then idle.
- Backpressure/overrun: press btn1, hold ready=0 for 20 cycles, release and re-press btn1 -> valid/id stable, overrun_o=0010. Ready gives exactly one event id=1. clr_ovr_i -> overrun_o=0.
- Reset mid-offer: in OFFER with id=3, pull rst_i low asynchronously -> evt_valid_o=0 immediately. With btn held high across reset release, no event is generated.
- Fairness: btn0 re-pressed every 4 cycles plus btn3 pending, ready=1 -> btn3 served no later than the second grant after it pends.
- With BTN_RELEASE_EVT_EN: press then release btn0 with ready=1 -> events (id0,type0) then (id0,type1). Without the macro, only (id0,type0).
